fir_filter_prog: RTL and testbench

FIR_FILTER_PROG -- requirements
Module: fir_filter_prog

---
 rtl/fir_pkg.sv | 50 +++++
 rtl/fir_sat_round.sv | 28 ++
 rtl/fir_filter_prog.sv | 132 +++++++++++++
 tb/tb_fir_filter_prog.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the programmable FIR filter:
//   - default DATA_W / COEF_W / TAPS / FRAC values
//   - acc_width(): full-precision accumulator width for a given configuration
//   - sat_round(): arithmetic shift by FRAC with optional round-half-up,
//     followed by saturation to a signed DATA_W range
// No ports (package).
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 20;
    localparam int DEF_TAPS   = 32;
    localparam int DEF_FRAC   = 16;

    // Working width for sat_round; wide enough for any legal accumulator.
    localparam int SR_W = 128;

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // acc must already be sign-extended to SR_W. The result lies within the
    // signed data_w range, so the caller can keep only the low data_w bits.
    function automatic logic signed [SR_W-1:0] sat_round(
        input logic signed [SR_W-1:0] acc,
        input int                     frac,
        input int                     data_w,
        input logic                   rnd
    );
        logic signed [SR_W-1:0] one;
        logic signed [SR_W-1:0] half;
        logic signed [SR_W-1:0] y;
        logic signed [SR_W-1:0] maxv;
        logic signed [SR_W-1:0] minv;
        one  = SR_W'(1);
        half = (rnd && (frac > 0)) ? (one <<< (frac - 1)) : '0;
        y    = (acc + half) >>> frac;
        maxv = (one <<< (data_w - 1)) - one;
        minv = ~maxv;
        if (y > maxv) begin
            return maxv;
        end else if (y < minv) begin
            return minv;
        end
        return y;
    endfunction

endpackage

// File: rtl/fir_sat_round.sv
// -----------------------------------------------------------------------------
// fir_sat_round
// Combinational scaling of the full-precision FIR accumulator down to an
// output sample: drop FRAC fractional bits (floor or round-half-up) and
// saturate to the signed DATA_W range.
// Ports:
//   acc_i    [ACC_W]  signed accumulator value
//   rnd_en_i          1 = round-half-up, 0 = floor truncation
//   y_o      [DATA_W] signed scaled and saturated result
// -----------------------------------------------------------------------------
module fir_sat_round
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = acc_width(DEF_DATA_W, DEF_COEF_W, DEF_TAPS),
    parameter int FRAC   = DEF_FRAC
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic                     rnd_en_i,
    output logic signed [DATA_W-1:0] y_o
);

    logic signed [SR_W-1:0] acc_ext;

    assign acc_ext = {{(SR_W - ACC_W){acc_i[ACC_W-1]}}, acc_i};
    assign y_o     = DATA_W'(sat_round(acc_ext, FRAC, DATA_W, rnd_en_i));

endmodule

// File: rtl/fir_filter_prog.sv
// -----------------------------------------------------------------------------
// fir_filter_prog
// Programmable direct-form FIR filter, one sample per clock. Each accepted
// sample is multiplied against the whole coefficient bank in a single cycle
// (full-precision MAC tree), scaled/saturated, and registered to the output.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   data_valid, data     input sample and its qualifier
//   flush                synchronous clear of delay line and fill counter
//   coef_we, coef_addr,  coefficient write port
//   coef_wdata
//   rnd_en               1 = round-half-up, 0 = floor truncation
//   fir_d, fir_valid     registered filter output and its one-cycle strobe
// -----------------------------------------------------------------------------
module fir_filter_prog
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int TAPS   = DEF_TAPS,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_valid,
    input  logic signed [DATA_W-1:0]  data,
    input  logic                      flush,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_wdata,
    input  logic                      rnd_en,
    output logic signed [DATA_W-1:0]  fir_d,
    output logic                      fir_valid
);

    localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
    localparam int AW    = $clog2(TAPS);
    localparam int CW    = $clog2(TAPS + 1);

    logic signed [DATA_W-1:0] x_q    [TAPS];
    logic signed [DATA_W-1:0] x_d    [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic        [CW-1:0]     cnt_q;
    logic signed [DATA_W-1:0] fir_d_q;
    logic                     fir_valid_q;
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [DATA_W-1:0] y_d;
    logic                     accept;
    logic                     warm;
    logic                     coef_ok;

    // Flush has priority: a sample presented with flush is dropped.
    assign accept = data_valid & ~flush;
    // The sample being accepted completes a full window when TAPS-1 older
    // samples are already in the line.
    assign warm   = (cnt_q >= CW'(TAPS - 1));

    // Out-of-range addresses only exist when TAPS is not a power of two.
    generate
        if (TAPS == (1 << AW)) begin : g_addr_full
            assign coef_ok = coef_we;
        end else begin : g_addr_chk
            assign coef_ok = coef_we & (int'(coef_addr) < TAPS);
        end
    endgenerate

    // Delay line as it will look after this sample is accepted; the MAC
    // uses it so the new sample participates in its own output.
    always_comb begin
        x_d[0] = data;
        for (int k = 1; k < TAPS; k++) begin
            x_d[k] = x_q[k-1];
        end
    end

    // Operands are widened to ACC_W first so no product or partial sum loses bits.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_d = sum_d + (ACC_W'(x_d[k]) * ACC_W'(coef_q[k]));
        end
    end

    fir_sat_round #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .FRAC   (FRAC)
    ) u_sat_round (
        .acc_i    (sum_d),
        .rnd_en_i (rnd_en),
        .y_o      (y_d)
    );

    // Coefficients are read combinationally from coef_q, so a write in the
    // same cycle as a sample only becomes visible to the following sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]    <= '0;
                coef_q[k] <= '0;
            end
            cnt_q       <= '0;
            fir_d_q     <= '0;
            fir_valid_q <= 1'b0;
        end else begin
            fir_valid_q <= accept & warm;
            if (accept & warm) begin
                fir_d_q <= y_d;
            end
            if (flush) begin
                for (int k = 0; k < TAPS; k++) begin
                    x_q[k] <= '0;
                end
                cnt_q <= '0;
            end else if (data_valid) begin
                for (int k = 0; k < TAPS; k++) begin
                    x_q[k] <= x_d[k];
                end
                if (cnt_q != CW'(TAPS)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
            if (coef_ok) begin
                coef_q[coef_addr] <= coef_wdata;
            end
        end
    end

    assign fir_d     = fir_d_q;
    assign fir_valid = fir_valid_q;

endmodule

// File: tb/tb_fir_filter_prog.sv
module tb_fir_filter_prog;

    localparam int DATA_W = 16;
    localparam int COEF_W = 20;
    localparam int TAPS   = 32;
    localparam int FRAC   = 16;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              data_valid = 1'b0;
    logic [DATA_W-1:0] data       = '0;
    logic              flush      = 1'b0;
    logic              coef_we    = 1'b0;
    logic [4:0]        coef_addr  = '0;
    logic [COEF_W-1:0] coef_wdata = '0;
    logic              rnd_en     = 1'b0;
    logic [DATA_W-1:0] fir_d;
    logic              fir_valid;

    always #5 clk = ~clk;

    fir_filter_prog #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS),
        .FRAC   (FRAC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .data       (data),
        .flush      (flush),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .rnd_en     (rnd_en),
        .fir_d      (fir_d),
        .fir_valid  (fir_valid)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_pushed = 0;
    int n_valid_seen = 0;

    // Reference model state
    logic signed [DATA_W-1:0] m_x    [TAPS];
    logic signed [COEF_W-1:0] m_coef [TAPS];
    int                       m_cnt;
    logic [DATA_W-1:0]        m_last_d;
    logic [DATA_W-1:0]        sb_q [$];

    function automatic logic [DATA_W-1:0] model_out(input longint sum, input logic rnd);
        longint y;
        if (rnd) y = (sum + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        else     y = sum >>> FRAC;
        if (y > 32767)  return 16'h7FFF;
        if (y < -32768) return 16'h8000;
        return y[DATA_W-1:0];
    endfunction

    task automatic model_clear_all();
        for (int k = 0; k < TAPS; k++) begin
            m_x[k]    = '0;
            m_coef[k] = '0;
        end
        m_cnt    = 0;
        m_last_d = '0;
        sb_q.delete();
    endtask

    // Drives one clock cycle of inputs (called at a falling edge), updates
    // the model, and returns at the next falling edge.
    task automatic drive(input logic dv, input logic [DATA_W-1:0] d, input logic fl,
                         input logic we, input logic [4:0] addr,
                         input logic [COEF_W-1:0] wd, input logic rnd);
        logic signed [DATA_W-1:0] xn [TAPS];
        longint sum;
        data_valid = dv;
        data       = d;
        flush      = fl;
        coef_we    = we;
        coef_addr  = addr;
        coef_wdata = wd;
        rnd_en     = rnd;
        if (fl) begin
            for (int k = 0; k < TAPS; k++) m_x[k] = '0;
            m_cnt = 0;
        end else if (dv) begin
            xn[0] = d;
            for (int k = 1; k < TAPS; k++) xn[k] = m_x[k-1];
            sum = 0;
            for (int k = 0; k < TAPS; k++) sum += longint'(xn[k]) * longint'(m_coef[k]);
            if (m_cnt >= TAPS - 1) begin
                sb_q.push_back(model_out(sum, rnd));
                n_pushed++;
            end
            for (int k = 0; k < TAPS; k++) m_x[k] = xn[k];
            if (m_cnt < TAPS) m_cnt++;
        end
        if (we) m_coef[addr] = wd;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        flush      = 1'b0;
        coef_we    = 1'b0;
    endtask

    task automatic sample(input logic [DATA_W-1:0] d, input logic rnd);
        drive(1'b1, d, 1'b0, 1'b0, 5'd0, '0, rnd);
    endtask

    task automatic write_coef(input logic [4:0] a, input logic [COEF_W-1:0] v);
        drive(1'b0, '0, 1'b0, 1'b1, a, v, 1'b0);
    endtask

    task automatic do_flush();
        drive(1'b0, '0, 1'b1, 1'b0, 5'd0, '0, 1'b0);
    endtask

    // Scoreboard monitor: samples outputs 3 time units after each rising edge.
    always @(posedge clk) begin
        #3;
        if (!rst) begin
            n_cmp++;
            if (fir_valid === 1'b1) begin
                n_valid_seen++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected_valid: fir_valid=1 (fir_d=%h) required fir_valid=0", fir_d);
                end else begin
                    m_last_d = sb_q.pop_front();
                    if (fir_d !== m_last_d) begin
                        n_err++;
                        $display("FAIL sb_data: fir_d=%h required %h", fir_d, m_last_d);
                    end
                end
            end else if (sb_q.size() != 0) begin
                n_err++;
                $display("FAIL sb_missing_valid: fir_valid=%b required 1", fir_valid);
                void'(sb_q.pop_front());
            end else if (fir_d !== m_last_d) begin
                n_err++;
                $display("FAIL sb_hold: fir_d=%h required %h", fir_d, m_last_d);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        model_clear_all();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (fir_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b required 0", fir_valid);
        end
        n_cmp++;
        if (fir_d !== 16'h0000) begin
            n_err++; $display("FAIL reset_data: got %h required 0000", fir_d);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        int first;
        first = -1;
        write_coef(5'd5, 20'h10000);
        for (int i = 1; i <= 40; i++) begin
            sample(16'(i), 1'b0);
            if (fir_valid === 1'b1 && first < 0) first = i;
            if (i == 31) begin
                n_cmp++;
                if (fir_valid !== 1'b0) begin
                    n_err++; $display("FAIL impulse_cold: fir_valid=%b required 0", fir_valid);
                end
            end
            if (i == 32) begin
                n_cmp++;
                if (fir_d !== 16'd27) begin
                    n_err++; $display("FAIL impulse_first: got %h required %h", fir_d, 16'd27);
                end
            end
            if (i == 40) begin
                n_cmp++;
                if (fir_d !== 16'd35) begin
                    n_err++; $display("FAIL impulse_last: got %h required %h", fir_d, 16'd35);
                end
            end
        end
        n_cmp++;
        if (first != 32) begin
            n_err++; $display("FAIL impulse_latency: first valid after sample %0d required 32", first);
        end
    endtask

    task automatic test_saturation();
        do_flush();
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), 20'h10000);
        for (int i = 0; i < 32; i++) sample(16'h7FFF, 1'b0);
        n_cmp++;
        if (fir_valid !== 1'b1 || fir_d !== 16'h7FFF) begin
            n_err++; $display("FAIL sat_pos: valid=%b fir_d=%h required 1/7fff", fir_valid, fir_d);
        end
        for (int i = 0; i < 32; i++) sample(16'h8000, 1'b1);
        n_cmp++;
        if (fir_d !== 16'h8000) begin
            n_err++; $display("FAIL sat_neg: got %h required 8000", fir_d);
        end
    endtask

    task automatic test_rounding();
        do_flush();
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), (k == 0) ? 20'h08000 : 20'h00000);
        for (int i = 0; i < 31; i++) sample(16'h0000, 1'b0);
        n_cmp++;
        if (fir_valid !== 1'b0) begin
            n_err++; $display("FAIL round_cold: fir_valid=%b required 0", fir_valid);
        end
        sample(16'h0003, 1'b1);
        n_cmp++;
        if (fir_d !== 16'h0002) begin n_err++; $display("FAIL round_pos_rnd: got %h required 0002", fir_d); end
        sample(16'h0003, 1'b0);
        n_cmp++;
        if (fir_d !== 16'h0001) begin n_err++; $display("FAIL round_pos_trunc: got %h required 0001", fir_d); end
        sample(16'hFFFD, 1'b1);
        n_cmp++;
        if (fir_d !== 16'hFFFF) begin n_err++; $display("FAIL round_neg_rnd: got %h required ffff", fir_d); end
        sample(16'hFFFD, 1'b0);
        n_cmp++;
        if (fir_d !== 16'hFFFE) begin n_err++; $display("FAIL round_neg_trunc: got %h required fffe", fir_d); end
    endtask

    task automatic test_collision();
        // coef[0] is 0x08000 (0.5) here; it is rewritten to 1.0 alongside a sample.
        drive(1'b1, 16'd100, 1'b0, 1'b1, 5'd0, 20'h10000, 1'b0);
        n_cmp++;
        if (fir_d !== 16'd50) begin n_err++; $display("FAIL collide_old: got %h required %h", fir_d, 16'd50); end
        sample(16'd100, 1'b0);
        n_cmp++;
        if (fir_d !== 16'd100) begin n_err++; $display("FAIL collide_new: got %h required %h", fir_d, 16'd100); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), 20'($urandom_range(0, 4095)) - 20'd2048);
        for (int i = 0; i < 40; i++) sample(16'($urandom), 1'($urandom));
        drive(1'b1, 16'h1234, 1'b1, 1'b0, 5'd0, '0, 1'b0);
        n_cmp++;
        if (fir_valid !== 1'b0 || fir_d !== m_last_d) begin
            n_err++; $display("FAIL flush_next: valid=%b fir_d=%h required 0/%h", fir_valid, fir_d, m_last_d);
        end
        for (int i = 1; i <= 32; i++) begin
            sample(16'($urandom), 1'($urandom));
            n_cmp++;
            if (fir_valid !== ((i == 32) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL flush_refill: sample %0d fir_valid=%b", i, fir_valid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 40; i++) sample(16'($urandom), 1'($urandom));
        #2;
        rst = 1'b1;
        model_clear_all();
        #1;
        n_cmp++;
        if (fir_valid !== 1'b0 || fir_d !== 16'h0000) begin
            n_err++; $display("FAIL async_reset: valid=%b fir_d=%h required 0/0000", fir_valid, fir_d);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) write_coef(5'(k), 20'($urandom_range(0, 65535)) - 20'd32768);
        for (int i = 1; i <= 32; i++) begin
            sample(16'($urandom), 1'($urandom));
            n_cmp++;
            if (fir_valid !== ((i == 32) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL reset_refill: sample %0d fir_valid=%b", i, fir_valid);
            end
        end
    endtask

    task automatic test_back_to_back_gaps();
        int pushed0;
        int seen0;
        pushed0 = n_pushed;
        seen0   = n_valid_seen;
        for (int i = 0; i < 300; i++) begin
            logic dv;
            logic fl;
            logic we;
            dv = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 49) == 0);
            we = ($urandom_range(0, 9) == 0);
            drive(dv, 16'($urandom), fl, we, 5'($urandom),
                  20'($urandom_range(0, 8191)) - 20'd4096, 1'($urandom));
        end
        drive(1'b0, '0, 1'b0, 1'b0, 5'd0, '0, 1'b0);
        n_cmp++;
        if ((n_valid_seen - seen0) != (n_pushed - pushed0)) begin
            n_err++; $display("FAIL gaps_count: outputs %0d required %0d",
                              n_valid_seen - seen0, n_pushed - pushed0);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_saturation();
        test_rounding();
        test_collision();
        test_flush();
        test_reset_midstream();
        test_back_to_back_gaps();
        drive(1'b0, '0, 1'b0, 1'b0, 5'd0, '0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
